// File: rtl/aer_encoder_sliced_rr.sv
// aer_encoder_sliced_rr: spike vector to AER addresses via NUM_SLICE interleaved slices, rotated lanes.
// Define AER_SERIAL_PORT_EN to build the round-robin merger and serial AER port.
module aer_encoder_sliced_rr #(
    parameter  int NUM_SLICE  = 10,
    parameter  int SLICE_BITS = 20,
    parameter  int AER_W      = 8,
    parameter  int CLASS_W    = 4,
    localparam int TOTAL      = NUM_SLICE * SLICE_BITS,
    localparam int COUNT_W    = $clog2(TOTAL + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_i,
    input  logic [TOTAL-1:0]             hot_vector_i,
    input  logic [CLASS_W-1:0]           class_i,
    input  logic [NUM_SLICE-1:0]         ready_i,
    output logic [NUM_SLICE*AER_W-1:0]   aer_o,
    output logic [NUM_SLICE-1:0]         valid_o,
    input  logic                         ser_mode_i,
    input  logic                         ser_ready_i,
    output logic [AER_W-1:0]             ser_aer_o,
    output logic                         ser_valid_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [COUNT_W-1:0]           count_o
);

    localparam int SEL_W   = $clog2(NUM_SLICE);
    localparam int CNT_MAX = (1 << COUNT_W) - 1;

    logic [SLICE_BITS-1:0] bits_q [NUM_SLICE];
    logic [SLICE_BITS-1:0] bits_d [NUM_SLICE];
    logic [AER_W-1:0]      addr_q [NUM_SLICE];
    logic [NUM_SLICE-1:0]  vld_q;
    logic [NUM_SLICE-1:0]  par_fire;
    logic [NUM_SLICE-1:0]  ser_pop;
    logic [SEL_W-1:0]      rot_q;
    logic                  ser_active;
    logic                  ser_fire;
    logic                  ser_vld_d;
    logic                  pending_d;
    logic                  busy_q;
    logic                  done_q;
    logic                  armed_q;
    logic [COUNT_W-1:0]    count_q;
    logic [COUNT_W-1:0]    count_d;
    int                    fire_sum;

    function automatic logic [SEL_W-1:0] slice_of(input int p, input logic [SEL_W-1:0] r);
        return SEL_W'((p + NUM_SLICE - int'(r)) % NUM_SLICE);
    endfunction

    function automatic logic [SEL_W-1:0] lane_of(input int s, input logic [SEL_W-1:0] r);
        return SEL_W'((s + int'(r)) % NUM_SLICE);
    endfunction

    function automatic logic [SLICE_BITS-1:0] extract(input logic [TOTAL-1:0] hv, input int s);
        logic [SLICE_BITS-1:0] r;
        for (int b = 0; b < SLICE_BITS; b++) r[b] = hv[b*NUM_SLICE + s];
        return r;
    endfunction

    // Lowest set bit mapped back to its original vector position; empty slices show 0.
    function automatic logic [AER_W-1:0] enc_addr(input logic [SLICE_BITS-1:0] v, input int s);
        int idx;
        idx = 0;
        for (int i = SLICE_BITS - 1; i >= 0; i--) if (v[i]) idx = i;
        return (v == '0) ? '0 : AER_W'(idx * NUM_SLICE + s);
    endfunction

    always_comb begin
        aer_o    = '0;
        valid_o  = '0;
        par_fire = '0;
        for (int p = 0; p < NUM_SLICE; p++) begin
            aer_o[p*AER_W +: AER_W] = addr_q[slice_of(p, rot_q)];
            valid_o[p]              = vld_q[slice_of(p, rot_q)] & ~ser_active;
        end
        for (int s = 0; s < NUM_SLICE; s++)
            par_fire[s] = vld_q[s] & ready_i[lane_of(s, rot_q)] & ~ser_active;
    end

    // Each accepted address clears the lowest pending bit of its slice.
    always_comb begin
        for (int s = 0; s < NUM_SLICE; s++) begin
            bits_d[s] = bits_q[s];
            if (start_i)
                bits_d[s] = extract(hot_vector_i, s);
            else if (par_fire[s] || ser_pop[s])
                bits_d[s] = bits_q[s] & (bits_q[s] - 1'b1);
        end
        pending_d = ser_vld_d;
        for (int s = 0; s < NUM_SLICE; s++) pending_d = pending_d | (|bits_d[s]);
    end

    always_comb begin
        fire_sum = int'(count_q) + int'(ser_fire);
        for (int s = 0; s < NUM_SLICE; s++) fire_sum = fire_sum + int'(par_fire[s]);
        count_d = (fire_sum > CNT_MAX) ? COUNT_W'(CNT_MAX) : COUNT_W'(fire_sum);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLICE; s++) begin
                bits_q[s] <= '0;
                addr_q[s] <= '0;
            end
            vld_q   <= '0;
            rot_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b0;
            count_q <= '0;
        end else begin
            for (int s = 0; s < NUM_SLICE; s++) begin
                bits_q[s] <= bits_d[s];
                addr_q[s] <= enc_addr(bits_d[s], s);
                vld_q[s]  <= |bits_d[s];
            end
            busy_q  <= pending_d;
            count_q <= start_i ? '0 : count_d;
            // A restart re-arms done for the new vector only; the aborted run never pulses.
            if (start_i) begin
                rot_q   <= SEL_W'(int'(class_i) % NUM_SLICE);
                done_q  <= ~pending_d;
                armed_q <= pending_d;
            end else if (armed_q && !pending_d) begin
                done_q  <= 1'b1;
                armed_q <= 1'b0;
            end else begin
                done_q  <= 1'b0;
            end
        end
    end

`ifdef AER_SERIAL_PORT_EN
    logic [SEL_W-1:0] grant_q;
    logic [SEL_W-1:0] pick_lane;
    logic             pick_ok;
    logic             ser_load;
    logic [AER_W-1:0] ser_aer_q;
    logic             ser_vld_q;

    // The output register pops its slice when it loads, so a slice can stream every cycle.
    always_comb begin
        pick_ok   = 1'b0;
        pick_lane = grant_q;
        for (int k = 1; k <= NUM_SLICE; k++) begin
            if (!pick_ok && vld_q[slice_of((int'(grant_q) + k) % NUM_SLICE, rot_q)]) begin
                pick_ok   = 1'b1;
                pick_lane = SEL_W'((int'(grant_q) + k) % NUM_SLICE);
            end
        end
        ser_fire  = ser_vld_q & ser_ready_i;
        ser_load  = ser_mode_i & pick_ok & (~ser_vld_q | ser_ready_i) & ~start_i;
        ser_vld_d = ~start_i & (ser_load | (ser_vld_q & ~ser_ready_i));
        for (int s = 0; s < NUM_SLICE; s++)
            ser_pop[s] = ser_load && (slice_of(int'(pick_lane), rot_q) == SEL_W'(s));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q   <= '0;
            ser_aer_q <= '0;
            ser_vld_q <= 1'b0;
        end else begin
            ser_vld_q <= ser_vld_d;
            if (ser_load) begin
                grant_q   <= pick_lane;
                ser_aer_q <= addr_q[slice_of(int'(pick_lane), rot_q)];
            end
        end
    end

    assign ser_active  = ser_mode_i;
    assign ser_aer_o   = ser_aer_q;
    assign ser_valid_o = ser_vld_q;
`else
    logic unused_ser;
    assign unused_ser  = ser_mode_i ^ ser_ready_i;
    assign ser_active  = 1'b0;
    assign ser_fire    = 1'b0;
    assign ser_vld_d   = 1'b0;
    assign ser_pop     = '0;
    assign ser_aer_o   = '0;
    assign ser_valid_o = 1'b0;
`endif

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign count_o = count_q;

endmodule

// File: tb/tb_aer_encoder_sliced_rr.sv
// tb_aer_encoder_sliced_rr: randomized and directed checks of aer_encoder_sliced_rr
// against a queue-based reference model of the address streams.
module tb_aer_encoder_sliced_rr;

    localparam int N    = 10;
    localparam int B    = 20;
    localparam int AW   = 8;
    localparam int CW   = 4;
    localparam int TOT  = N * B;
    localparam int CNTW = $clog2(TOT + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start_i;
    logic [TOT-1:0]    hot_vector_i;
    logic [CW-1:0]     class_i;
    logic [N-1:0]      ready_i;
    logic [N*AW-1:0]   aer_o;
    logic [N-1:0]      valid_o;
    logic              ser_mode_i;
    logic              ser_ready_i;
    logic [AW-1:0]     ser_aer_o;
    logic              ser_valid_o;
    logic              busy_o;
    logic              done_o;
    logic [CNTW-1:0]   count_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: per-slice queues of still-unsent addresses in ascending order.
    int pend [N][$];
    int m_rot;
    int m_count;
    bit m_done;
    bit m_armed;

    always #5 clk = ~clk;

    aer_encoder_sliced_rr #(.NUM_SLICE(N), .SLICE_BITS(B), .AER_W(AW), .CLASS_W(CW)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .hot_vector_i(hot_vector_i),
        .class_i(class_i), .ready_i(ready_i), .aer_o(aer_o), .valid_o(valid_o),
        .ser_mode_i(ser_mode_i), .ser_ready_i(ser_ready_i), .ser_aer_o(ser_aer_o),
        .ser_valid_o(ser_valid_o), .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
    );

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit modelIdle();
        for (int s = 0; s < N; s++) if (pend[s].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        for (int s = 0; s < N; s++) pend[s].delete();
        m_rot = 0; m_count = 0; m_done = 1'b0; m_armed = 1'b0;
    endtask

    task automatic modelStart(input logic [TOT-1:0] vec, input int cls);
        for (int s = 0; s < N; s++) pend[s].delete();
        for (int a = 0; a < TOT; a++) if (vec[a]) pend[a % N].push_back(a);
        m_rot   = cls % N;
        m_count = 0;
        m_done  = (vec == '0);
        m_armed = (vec != '0);
    endtask

    task automatic modelStep(input logic [N-1:0] rdy);
        int s;
        for (int p = 0; p < N; p++) begin
            s = (p - m_rot + N) % N;
            if (rdy[p] && pend[s].size() > 0) begin
                void'(pend[s].pop_front());
                if (m_count < (1 << CNTW) - 1) m_count++;
            end
        end
        if (m_armed && modelIdle()) begin
            m_done  = 1'b1;
            m_armed = 1'b0;
        end else begin
            m_done = 1'b0;
        end
    endtask

    task automatic checkCycle();
        logic [N-1:0]    ev;
        logic [N*AW-1:0] ea;
        logic [N*AW-1:0] ga;
        int s;
        ev = '0; ea = '0; ga = '0;
        for (int p = 0; p < N; p++) begin
            s = (p - m_rot + N) % N;
            if (pend[s].size() > 0) begin
                ev[p] = 1'b1;
                ea[p*AW +: AW] = AW'(pend[s][0]);
                ga[p*AW +: AW] = aer_o[p*AW +: AW];
            end
        end
        checkOutput("valid", valid_o, ev);
        checkOutput("aer", ga, ea);
        checkOutput("busy", busy_o, !modelIdle());
        checkOutput("done", done_o, m_done);
        checkOutput("count", count_o, m_count);
        checkOutput("serValid", ser_valid_o, 1'b0);
        checkOutput("serAer", ser_aer_o, '0);
    endtask

    task automatic applyStimulus(input logic st, input logic [TOT-1:0] vec,
                                 input logic [CW-1:0] cls, input logic [N-1:0] rdy);
        start_i = st; hot_vector_i = vec; class_i = cls; ready_i = rdy;
`ifndef AER_SERIAL_PORT_EN
        ser_mode_i  = 1'($urandom_range(0, 1));
        ser_ready_i = 1'($urandom_range(0, 1));
`endif
        if (st) modelStart(vec, int'(cls));
        else    modelStep(rdy);
        @(posedge clk); #1;
        start_i = 1'b0;
        checkCycle();
    endtask

    task automatic doReset(input logic withStart);
        reset = 1'b1; start_i = withStart;
        hot_vector_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        class_i = CW'($urandom_range(0, 15));
        @(posedge clk); #1;
        reset = 1'b0; start_i = 1'b0;
        modelReset();
        checkCycle();
        checkOutput("resetAer", aer_o, '0);
    endtask

    function automatic logic [TOT-1:0] randVec(input int density);
        logic [TOT-1:0] v;
        for (int a = 0; a < TOT; a++) v[a] = ($urandom_range(0, density - 1) == 0);
        return v;
    endfunction

    function automatic logic [N-1:0] randReady();
        logic [N-1:0] r;
        for (int p = 0; p < N; p++) r[p] = ($urandom_range(0, 3) != 0);
        return r;
    endfunction

`ifdef AER_SERIAL_PORT_EN
    task automatic serialRun(input logic [TOT-1:0] vec, input bit directed);
        bit           seen [TOT];
        int           got;
        int           expN;
        bit           holding;
        bit           ok;
        logic [AW-1:0] lastAddr;
        got = 0; expN = 0; holding = 1'b0; lastAddr = '0;
        for (int a = 0; a < TOT; a++) begin
            seen[a] = 1'b0;
            if (vec[a]) expN++;
        end
        ser_mode_i = 1'b1; ser_ready_i = 1'b1; ready_i = '1;
        start_i = 1'b1; hot_vector_i = vec; class_i = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c <= 600 && got < expN; c++) begin
            checkOutput("serParValid", valid_o, '0);
            if (holding) begin
                checkOutput("serHoldValid", ser_valid_o, 1'b1);
                checkOutput("serHoldAer", ser_aer_o, lastAddr);
            end
            ser_ready_i = directed ? 1'b1 : 1'($urandom_range(0, 1));
            if (ser_valid_o && ser_ready_i) begin
                ok = (int'(ser_aer_o) < TOT);
                if (ok) ok = vec[ser_aer_o] && !seen[ser_aer_o];
                checkOutput("serAddrOk", ok, 1'b1);
                if (directed) begin
                    checkOutput("serSeq", ser_aer_o, got + 1);
                    checkOutput("serCycle", c, got + 2);
                end
                if (int'(ser_aer_o) < TOT) seen[ser_aer_o] = 1'b1;
                got++;
            end
            holding  = ser_valid_o && !ser_ready_i;
            lastAddr = ser_aer_o;
            @(posedge clk); #1;
        end
        checkOutput("serGot", got, expN);
        checkOutput("serCount", count_o, expN);
        checkOutput("serDone", done_o, 1'b1);
        ser_mode_i = 1'b0;
        applyStimulus(1'b0, vec, '0, '1);
    endtask
`endif

    initial begin
        logic [TOT-1:0] vec;
        int             doneAt;
        int             fullCycles;
        int             doneCount;
        bit             st;

        reset = 1'b1; start_i = 1'b0; hot_vector_i = '0; class_i = '0; ready_i = '0;
        ser_mode_i = 1'b0; ser_ready_i = 1'b0;
        @(posedge clk); #1;
        doReset(1'b1);
        applyStimulus(1'b0, '0, '0, '1);

        // Directed: bits {0,10,11,199}, class 0.
        vec = '0; vec[0] = 1'b1; vec[10] = 1'b1; vec[11] = 1'b1; vec[199] = 1'b1;
        applyStimulus(1'b1, vec, '0, '1);
        checkOutput("dirLane9", aer_o[9*AW +: AW], 199);
        doneAt = -1;
        for (int c = 2; c <= 6; c++) begin
            applyStimulus(1'b0, vec, '0, '1);
            if (done_o && doneAt < 0) doneAt = c;
        end
        checkOutput("dirDoneCycle", doneAt, 3);
        checkOutput("dirCount", count_o, 4);

        // Class 3 rotation with lane 8 back-pressured for four cycles.
        vec = '0; vec[5] = 1'b1;
        applyStimulus(1'b1, vec, 4'd3, '1);
        for (int c = 0; c < 4; c++) applyStimulus(1'b0, vec, 4'd3, ~(10'b1 << 8));
        checkOutput("holdLane8", valid_o, 10'h100);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, vec, 4'd3, '1);
        checkOutput("rotCount", count_o, 1);

        // All bits set.
        vec = '1; fullCycles = 0; doneCount = 0;
        applyStimulus(1'b1, vec, '0, '1);
        for (int c = 0; c < 25; c++) begin
            if (valid_o == '1) fullCycles++;
            applyStimulus(1'b0, vec, '0, '1);
            if (done_o) doneCount++;
        end
        checkOutput("fullCycles", fullCycles, 20);
        checkOutput("fullDone", doneCount, 1);
        checkOutput("fullCount", count_o, 200);

        // Abort mid-drain with a new vector {42}.
        vec = randVec(3);
        applyStimulus(1'b1, vec, CW'($urandom_range(0, 15)), '1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, vec, class_i, randReady());
        vec = '0; vec[42] = 1'b1;
        applyStimulus(1'b1, vec, '0, '1);
        checkOutput("abortValid", valid_o, 10'b100);
        checkOutput("abortAer", aer_o[2*AW +: AW], 42);
        checkOutput("abortCount", count_o, 0);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, vec, '0, '1);

        // Randomized runs with random back-pressure and occasional aborts.
        for (int r = 0; r < 25; r++) begin
            vec = (r % 5 == 0) ? '0 : randVec(1 + int'($urandom_range(1, 10)));
            applyStimulus(1'b1, vec, CW'($urandom_range(0, 15)), randReady());
            for (int c = 0; c < 300 && !(modelIdle() && !m_done); c++) begin
                st = ($urandom_range(0, 39) == 0);
                if (st) vec = randVec(8);
                applyStimulus(st, vec, st ? CW'($urandom_range(0, 15)) : class_i, randReady());
            end
            applyStimulus(1'b0, vec, class_i, randReady());
        end

        // Reset mid-run, with a concurrent start that must be ignored.
        vec = randVec(4);
        applyStimulus(1'b1, vec, CW'($urandom_range(0, 15)), '1);
        applyStimulus(1'b0, vec, class_i, randReady());
        doReset(1'b1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, vec, class_i, '1);

`ifdef AER_SERIAL_PORT_EN
        vec = '0; vec[1] = 1'b1; vec[2] = 1'b1; vec[3] = 1'b1;
        serialRun(vec, 1'b1);
        for (int r = 0; r < 4; r++) serialRun(randVec(6), 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
